// File: rtl/vga_timing.sv
// 640x480 VGA pixel-timing generator: wrapping scan counters (stage 0) feeding
// registered sync, blank and colour outputs (stage 1), all advanced on pix_en.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [7:0]  i_r,
    input  logic [7:0]  i_g,
    input  logic [7:0]  i_b,
    output logic [11:0] CounterX,
    output logic [11:0] CounterY,
    output logic        frame_start,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] X_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] Y_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] X_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] Y_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] x_q, x_d, y_q, y_d;
    logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d, frame_q, frame_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        active, hs_n, vs_n;

    always_comb begin
        // NOTE: every signal gets a hold default first, so no path leaves one unassigned (no latch).
        x_d       = x_q;
        y_d       = y_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        frame_d   = frame_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;

        active = (x_q < X_ACT) && (y_q < Y_ACT);
        hs_n   = !((x_q >= HS_START) && (x_q < HS_END));
        vs_n   = !((y_q >= VS_START) && (y_q < VS_END));

        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 12'd1;
            end else begin
                x_d = x_q + 12'd1;
            end
            hs_d      = hs_n;
            vs_d      = vs_n;
            blank_n_d = active;
            frame_d   = (x_q == X_LAST) && (y_q == Y_LAST);
            // Colour inputs belong to the current counters, so they share the decode's tick.
            r_d       = active ? i_r : 8'd0;
            g_d       = active ? i_g : 8'd0;
            b_d       = active ? i_b : 8'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            frame_q   <= 1'b0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            frame_q   <= frame_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign CounterX    = x_q;
    assign CounterY    = y_q;
    assign frame_start = frame_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a full-size instance for line-level timing and a
// shrunken instance (16x11 totals) so whole frames fit in a short run.
module tb_vga_timing;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } st_t;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic [11:0] cx_d, cy_d, cx_s, cy_s;
    logic        fs_d, hs_d, vs_d, bl_d, sn_d, fs_s, hs_s, vs_s, bl_s, sn_s;
    logic [7:0]  r_d, g_d, b_d, r_s, g_s, b_s;
    logic [7:0]  ir_d, ig_d, ib_d, ir_s, ig_s, ib_s;
    st_t         obs_d, obs_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ir_d = cx_d[7:0];
    assign ig_d = cy_d[7:0];
    assign ib_d = 8'hA5;
    assign ir_s = cx_s[7:0];
    assign ig_s = cy_s[7:0];
    assign ib_s = 8'hA5;

    assign obs_d = {cx_d, cy_d, hs_d, vs_d, bl_d, fs_d, r_d, g_d, b_d};
    assign obs_s = {cx_s, cy_s, hs_s, vs_s, bl_s, fs_s, r_s, g_s, b_s};

    vga_timing dut_d (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .i_r(ir_d), .i_g(ig_d), .i_b(ib_d),
        .CounterX(cx_d), .CounterY(cy_d), .frame_start(fs_d),
        .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_BLANK_N(bl_d), .VGA_SYNC_N(sn_d),
        .VGA_R(r_d), .VGA_G(g_d), .VGA_B(b_d)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .i_r(ir_s), .i_g(ig_s), .i_b(ib_s),
        .CounterX(cx_s), .CounterY(cy_s), .frame_start(fs_s),
        .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sn_s),
        .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
    );

    // Expected state after n pixel ticks since reset release (n=0 is the reset state).
    function automatic st_t exp_state(input int n, input int ha, input int hf, input int hsw,
                                      input int hb, input int va, input int vf, input int vsw,
                                      input int vb);
        int ht, vt, p, px, py;
        bit act;
        st_t e;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (n == 0) return e;
        e.x  = 12'(n % ht);
        e.y  = 12'((n / ht) % vt);
        p    = n - 1;
        px   = p % ht;
        py   = (p / ht) % vt;
        act  = (px < ha) && (py < va);
        e.bl = act;
        e.hs = !((px >= ha + hf) && (px < ha + hf + hsw));
        e.vs = !((py >= va + vf) && (py < va + vf + vsw));
        e.fs = (n % (ht * vt)) == 0;
        if (act) begin
            e.r = 8'(px);
            e.g = 8'(py);
            e.b = 8'hA5;
        end
        return e;
    endfunction

    function automatic st_t exp_d(input int n);
        return exp_state(n, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic st_t exp_s(input int n);
        return exp_state(n, 8, 2, 3, 3, 6, 1, 2, 2);
    endfunction

    task automatic cycle(input logic pe);
        pix_en = pe;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b1);
        cycle(1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_d !== exp_d(0)) begin
            errors++;
            $display("FAIL reset_full state got %h want %h", obs_d, exp_d(0));
        end
        checks++;
        if (obs_s !== exp_s(0)) begin
            errors++;
            $display("FAIL reset_small state got %h want %h", obs_s, exp_s(0));
        end
        checks++;
        if ({sn_d, sn_s} !== 2'b00) begin
            errors++;
            $display("FAIL sync_n got %b want 00", {sn_d, sn_s});
        end
    endtask

    task automatic test_line();
        int bad = 0, first_bad = -1, hs_first = -1, hs_low = 0;
        st_t bad_obs, bad_exp;
        do_reset();
        for (int t = 1; t <= 1000; t++) begin
            cycle(1'b1);
            if (obs_d !== exp_d(t)) begin
                if (bad == 0) begin
                    first_bad = t;
                    bad_obs = obs_d;
                    bad_exp = exp_d(t);
                end
                bad++;
            end
            if (hs_d === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = t;
            end
            if (t == 1) begin
                checks++;
                if ({bl_d, r_d, g_d, b_d} !== {1'b1, 24'h0000A5}) begin
                    errors++;
                    $display("FAIL first_pixel got %h want 10000a5", {bl_d, r_d, g_d, b_d});
                end
            end
            if (t == 641) begin
                checks++;
                if ({bl_d, r_d, g_d, b_d} !== 25'd0) begin
                    errors++;
                    $display("FAIL hblank_rgb got %h want 0", {bl_d, r_d, g_d, b_d});
                end
            end
            if (t == 799) begin
                checks++;
                if ({cx_d, cy_d} !== {12'd799, 12'd0}) begin
                    errors++;
                    $display("FAIL x_last got %0d,%0d want 799,0", cx_d, cy_d);
                end
            end
            if (t == 800) begin
                checks++;
                if ({cx_d, cy_d} !== {12'd0, 12'd1}) begin
                    errors++;
                    $display("FAIL x_wrap got %0d,%0d want 0,1", cx_d, cy_d);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL line_seq bad=%0d first t=%0d got %h want %h", bad, first_bad, bad_obs, bad_exp);
        end
        checks++;
        if (hs_first !== 657) begin
            errors++;
            $display("FAIL hs_first got %0d want 657", hs_first);
        end
        checks++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL hs_width got %0d want 96", hs_low);
        end
    endtask

    task automatic test_frame();
        int bad = 0, first_bad = -1, vs_low = 0, bl_high = 0, fs_cnt = 0, fs_first = -1;
        st_t bad_obs, bad_exp;
        do_reset();
        for (int t = 1; t <= 352; t++) begin
            cycle(1'b1);
            if (obs_s !== exp_s(t)) begin
                if (bad == 0) begin
                    first_bad = t;
                    bad_obs = obs_s;
                    bad_exp = exp_s(t);
                end
                bad++;
            end
            if (vs_s === 1'b0) vs_low++;
            if (bl_s === 1'b1) bl_high++;
            if (fs_s === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = t;
            end
            if (t == 175) begin
                checks++;
                if ({cx_s, cy_s, fs_s} !== {12'd15, 12'd10, 1'b0}) begin
                    errors++;
                    $display("FAIL frame_last got %0d,%0d fs=%b want 15,10 fs=0", cx_s, cy_s, fs_s);
                end
            end
            if (t == 176) begin
                checks++;
                if ({cx_s, cy_s, fs_s} !== {12'd0, 12'd0, 1'b1}) begin
                    errors++;
                    $display("FAIL frame_wrap got %0d,%0d fs=%b want 0,0 fs=1", cx_s, cy_s, fs_s);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL frame_seq bad=%0d first t=%0d got %h want %h", bad, first_bad, bad_obs, bad_exp);
        end
        checks++;
        if (vs_low !== 64) begin
            errors++;
            $display("FAIL vs_width got %0d want 64", vs_low);
        end
        checks++;
        if (bl_high !== 96) begin
            errors++;
            $display("FAIL blank_area got %0d want 96", bl_high);
        end
        checks++;
        if ({fs_cnt, fs_first} !== {32'd2, 32'd176}) begin
            errors++;
            $display("FAIL frame_pulses got cnt=%0d first=%0d want cnt=2 first=176", fs_cnt, fs_first);
        end
    endtask

    task automatic test_pix_en_div2();
        int n = 0, bad = 0, first_bad = -1, fs_first = -1, fs_second = -1;
        logic pe;
        do_reset();
        for (int c = 1; c <= 704; c++) begin
            pe = (c % 2) == 1;
            cycle(pe);
            if (pe) n++;
            if (obs_s !== exp_s(n) || obs_d !== exp_d(n)) begin
                if (bad == 0) first_bad = c;
                bad++;
            end
            if (fs_s === 1'b1 && pe) begin
                if (fs_first < 0) fs_first = c;
                else if (fs_second < 0) fs_second = c;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL div2_hold bad=%0d first cycle=%0d", bad, first_bad);
        end
        checks++;
        if ({fs_first, fs_second} !== {32'd351, 32'd703}) begin
            errors++;
            $display("FAIL div2_period got %0d,%0d want 351,703", fs_first, fs_second);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0, first_bad = -1;
        do_reset();
        for (int t = 1; t <= 140; t++) cycle(1'b1);
        checks++;
        if ({cx_s, cy_s, hs_s, vs_s} !== {12'd12, 12'd8, 2'b00}) begin
            errors++;
            $display("FAIL pre_reset got %0d,%0d hs=%b vs=%b want 12,8 hs=0 vs=0", cx_s, cy_s, hs_s, vs_s);
        end
        reset = 1'b1;
        cycle(1'b1);
        checks++;
        if (obs_s !== exp_s(0)) begin
            errors++;
            $display("FAIL mid_reset_small got %h want %h", obs_s, exp_s(0));
        end
        checks++;
        if (obs_d !== exp_d(0)) begin
            errors++;
            $display("FAIL mid_reset_full got %h want %h", obs_d, exp_d(0));
        end
        reset = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            cycle(1'b1);
            if (obs_s !== exp_s(t) || obs_d !== exp_d(t)) begin
                if (bad == 0) first_bad = t;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL resume bad=%0d first t=%0d", bad, first_bad);
        end
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_line();
        test_frame();
        test_pix_en_div2();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
